// File: rtl/dmem_pkg.sv
// Shared types and helpers for the load/store data memory.
package dmem_pkg;

   typedef enum logic [2:0] {
      MODE_BYTE  = 3'b000,
      MODE_HALF  = 3'b001,
      MODE_WORD  = 3'b010,
      MODE_UBYTE = 3'b011,
      MODE_UHALF = 3'b100
   } mem_mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SPLIT = 1'b1
   } state_e;

   // Access size in bytes; illegal encodings report 4 but are faulted elsewhere.
   function automatic logic [2:0] mode_size(input mem_mode_e m);
      case (m)
         MODE_BYTE, MODE_UBYTE: return 3'd1;
         MODE_HALF, MODE_UHALF: return 3'd2;
         default:               return 3'd4;
      endcase
   endfunction

   // Loads in these modes are sign-extended; the unsigned modes zero-extend.
   function automatic logic mode_signed(input mem_mode_e m);
      case (m)
         MODE_BYTE, MODE_HALF, MODE_WORD: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word array with per-byte write enables and a registered read.
module dmem_bank #(
   parameter int unsigned WORDS = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          clk,
   input  logic          i_en,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [WORDS];
   logic [31:0] r_rdata;

   // Byte-lane writes and read-before-write output register; contents are never reset.
   always_ff @(posedge clk) begin
      if (i_en) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/lsu_dmem.sv
// Load/store data memory: request/response handshake, fault checks,
// two-beat splitting of word-crossing accesses, and load extension.
module lsu_dmem
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_BYTES    = 1024,
   parameter bit          MISALIGN_SPLIT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_mode,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault
);

   localparam int unsigned WORDS = DEPTH_BYTES / 4;
   localparam int unsigned AW    = $clog2(WORDS);

   state_e        r_state, w_state_nxt;

   // Decoded request
   mem_mode_e     w_mode;
   logic [2:0]    w_size;
   logic [1:0]    w_off;
   logic [AW-1:0] w_idx;
   logic [32:0]   w_last;
   logic          w_cross, w_fault, w_split, w_accept;
   logic [7:0]    w_base, w_mask;
   logic [63:0]   w_wdata64;

   // Registered request for beat 1 and for the response cycle
   mem_mode_e     r_mode;
   logic [1:0]    r_off;
   logic [AW-1:0] r_idx_hi;
   logic          r_we;
   logic [3:0]    r_mask_hi;
   logic [31:0]   r_wdata_hi;

   // Bank port
   logic          w_bank_en;
   logic [3:0]    w_bank_we;
   logic [AW-1:0] w_bank_addr;
   logic [31:0]   w_bank_wdata, w_bank_rdata;

   // Response path
   logic          r_rsp_valid, r_rsp_fault, r_rsp_load, r_rsp_split;
   logic [31:0]   r_beat0;
   logic [63:0]   w_join;
   logic [31:0]   w_sh32, w_ext;
   logic          w_sgn;

   assign req_ready = rst_n && (r_state == ST_IDLE);
   assign w_accept  = req_valid && req_ready;

   assign w_mode  = mem_mode_e'(req_mode);
   assign w_size  = mode_size(w_mode);
   assign w_off   = req_addr[1:0];
   assign w_idx   = req_addr[AW+1:2];
   assign w_last  = {1'b0, req_addr} + {30'b0, w_size} - 33'd1;
   assign w_cross = ({1'b0, w_off} + w_size) > 3'd4;
   assign w_fault = (req_mode > 3'd4) || (w_last >= 33'(DEPTH_BYTES)) ||
                    (w_cross && !MISALIGN_SPLIT);
   assign w_split = w_cross && !w_fault;

   assign w_base    = (w_size == 3'd1) ? 8'h01 : (w_size == 3'd2) ? 8'h03 : 8'h0F;
   assign w_mask    = w_base << w_off;
   assign w_wdata64 = {32'b0, req_wdata} << {w_off, 3'b000};

   dmem_bank #(
      .WORDS (WORDS),
      .AW    (AW)
   ) u_bank (
      .clk     (clk),
      .i_en    (w_bank_en),
      .i_we    (w_bank_we),
      .i_addr  (w_bank_addr),
      .i_wdata (w_bank_wdata),
      .o_rdata (w_bank_rdata)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and bank control: beat 0 on the accept edge, beat 1 from the registered request
   always_comb begin
      w_state_nxt  = r_state;
      w_bank_en    = 1'b0;
      w_bank_we    = '0;
      w_bank_addr  = w_idx;
      w_bank_wdata = w_wdata64[31:0];
      case (r_state)
         ST_IDLE: begin
            if (w_accept && !w_fault) begin
               w_bank_en = 1'b1;
               w_bank_we = req_we ? w_mask[3:0] : 4'b0000;
               if (w_split) w_state_nxt = ST_SPLIT;
            end
         end
         ST_SPLIT: begin
            w_bank_en    = 1'b1;
            w_bank_addr  = r_idx_hi;
            w_bank_we    = r_we ? r_mask_hi : 4'b0000;
            w_bank_wdata = r_wdata_hi;
            w_state_nxt  = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Capture request fields on accept so beat 1 and the response ignore req_*
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode     <= MODE_BYTE;
         r_off      <= '0;
         r_idx_hi   <= '0;
         r_we       <= 1'b0;
         r_mask_hi  <= '0;
         r_wdata_hi <= '0;
      end else if (w_accept) begin
         r_mode     <= w_mode;
         r_off      <= w_off;
         r_idx_hi   <= w_idx + AW'(1);
         r_we       <= req_we;
         r_mask_hi  <= w_mask[7:4];
         r_wdata_hi <= w_wdata64[63:32];
      end
   end

   // Response flags and the beat-0 word of a split load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_fault <= 1'b0;
         r_rsp_load  <= 1'b0;
         r_rsp_split <= 1'b0;
         r_beat0     <= '0;
      end else begin
         r_rsp_valid <= (w_accept && !w_split) || (r_state == ST_SPLIT);
         r_rsp_fault <= w_accept && w_fault;
         r_rsp_split <= (r_state == ST_SPLIT);
         if (r_state == ST_SPLIT) begin
            r_rsp_load <= !r_we;
            r_beat0    <= w_bank_rdata;
         end else begin
            r_rsp_load <= w_accept && !req_we && !w_fault;
         end
      end
   end

   // The bank output is already registered, so extension works directly on it
   // during the response cycle rather than adding a further pipeline stage.
   always_comb begin
      w_join = r_rsp_split ? {w_bank_rdata, r_beat0} : {32'b0, w_bank_rdata};
      w_sh32 = 32'(w_join >> {r_off, 3'b000});
      w_sgn  = mode_signed(r_mode);
      case (mode_size(r_mode))
         3'd1:    w_ext = {{24{w_sgn & w_sh32[7]}}, w_sh32[7:0]};
         3'd2:    w_ext = {{16{w_sgn & w_sh32[15]}}, w_sh32[15:0]};
         default: w_ext = w_sh32;
      endcase
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_fault = r_rsp_fault;
   assign rsp_rdata = (r_rsp_valid && r_rsp_load) ? w_ext : '0;

endmodule

// File: tb/tb_lsu_dmem.sv
// Randomised and directed bench for lsu_dmem with a byte-array reference model.
module tb_lsu_dmem;

   localparam int unsigned DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   // Instance A: splitting enabled
   logic        a_valid = 1'b0, a_we = 1'b0;
   logic [31:0] a_addr = '0, a_wdata = '0;
   logic [2:0]  a_mode = '0;
   logic        a_ready, a_rvalid, a_fault;
   logic [31:0] a_rdata;
   // Instance B: misaligned crossings fault
   logic        b_valid = 1'b0, b_we = 1'b0;
   logic [31:0] b_addr = '0, b_wdata = '0;
   logic [2:0]  b_mode = '0;
   logic        b_ready, b_rvalid, b_fault;
   logic [31:0] b_rdata;

   int unsigned n_tests = 0;
   int unsigned n_fails = 0;

   logic [7:0] m_a [DEPTH];
   logic [7:0] m_b [DEPTH];

   always #5 clk = ~clk;

   lsu_dmem #(.DEPTH_BYTES(DEPTH), .MISALIGN_SPLIT(1'b1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
      .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata), .req_mode(a_mode),
      .rsp_valid(a_rvalid), .rsp_rdata(a_rdata), .rsp_fault(a_fault));

   lsu_dmem #(.DEPTH_BYTES(DEPTH), .MISALIGN_SPLIT(1'b0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
      .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata), .req_mode(b_mode),
      .rsp_valid(b_rvalid), .rsp_rdata(b_rdata), .rsp_fault(b_fault));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: applies the access to the byte array and returns the expected response.
   function automatic void model(input bit ns, input bit we, input logic [31:0] addr,
                                 input logic [2:0] mode, input logic [31:0] wd,
                                 output logic [31:0] rd, output bit flt, output bit split);
      int unsigned size, off;
      logic [63:0] last;
      logic [31:0] v;
      size  = (mode == 3'd0 || mode == 3'd3) ? 1 : (mode == 3'd1 || mode == 3'd4) ? 2 : 4;
      off   = int'(addr % 4);
      last  = 64'(addr) + 64'(size) - 64'd1;
      flt   = (mode > 3'd4) || (last >= 64'(DEPTH)) || (ns && (off + size > 4));
      split = !flt && (off + size > 4);
      rd    = '0;
      if (!flt) begin
         if (we) begin
            for (int unsigned i = 0; i < size; i++) begin
               if (ns) m_b[addr + i] = wd[8*i +: 8];
               else    m_a[addr + i] = wd[8*i +: 8];
            end
         end else begin
            v = '0;
            for (int unsigned i = 0; i < size; i++)
               v[8*i +: 8] = ns ? m_b[addr + i] : m_a[addr + i];
            if (mode == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (mode == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            rd = v;
         end
      end
   endfunction

   task automatic do_req(input bit ns, input bit we, input logic [31:0] addr,
                         input logic [2:0] mode, input logic [31:0] wd,
                         input string tag, output logic [31:0] rd_obs);
      logic [31:0] erd;
      bit          ef, es;
      int          k;
      @(negedge clk);
      k = 0;
      while (!(ns ? b_ready : a_ready) && k < 8) begin
         @(negedge clk);
         k++;
      end
      check($sformatf("%s_ready", tag), 32'(ns ? b_ready : a_ready), 32'd1);
      if (ns) begin
         b_valid = 1'b1; b_we = we; b_addr = addr; b_mode = mode; b_wdata = wd;
      end else begin
         a_valid = 1'b1; a_we = we; a_addr = addr; a_mode = mode; a_wdata = wd;
      end
      @(posedge clk);
      model(ns, we, addr, mode, wd, erd, ef, es);
      #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      if (es) begin
         check($sformatf("%s_split_ready", tag), 32'(a_ready), 32'd0);
         check($sformatf("%s_split_gap", tag), 32'(a_rvalid), 32'd0);
         @(posedge clk);
         #1;
      end
      check($sformatf("%s_rsp_valid", tag), 32'(ns ? b_rvalid : a_rvalid), 32'd1);
      check($sformatf("%s_fault", tag), 32'(ns ? b_fault : a_fault), 32'(ef));
      check($sformatf("%s_rdata", tag), ns ? b_rdata : a_rdata, erd);
      rd_obs = ns ? b_rdata : a_rdata;
      @(posedge clk);
      #1;
      check($sformatf("%s_pulse_end", tag), 32'(ns ? b_rvalid : a_rvalid), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, old20, erd;
      logic [7:0]  old40, old41;
      bit          ef, es;
      logic        b2b_we   [8];
      logic [31:0] b2b_addr [8];
      logic [31:0] b2b_data [8];

      // Reset values
      #12;
      check("rst_ready_a", 32'(a_ready), 32'd0);
      check("rst_ready_b", 32'(b_ready), 32'd0);
      check("rst_rsp_valid", 32'(a_rvalid), 32'd0);
      check("rst_rsp_rdata", a_rdata, 32'd0);
      check("rst_rsp_fault", 32'(a_fault), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", 32'(a_ready), 32'd1);

      // Fill memory A so every byte is known to the model
      for (int unsigned w = 0; w < DEPTH / 4; w++)
         do_req(1'b0, 1'b1, 32'(w * 4), 3'd2, $urandom, "init", rd);

      // Word store and loads
      do_req(1'b0, 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, "st_w10", rd);
      do_req(1'b0, 1'b0, 32'h10, 3'd2, 32'h0, "ld_w10", rd);
      check("ld_w10_const", rd, 32'hDEAD_BEEF);
      do_req(1'b0, 1'b0, 32'h12, 3'd4, 32'h0, "ld_uh12", rd);
      check("ld_uh12_const", rd, 32'h0000_DEAD);

      // Byte store, sign and zero extension, neighbour bytes untouched
      do_req(1'b0, 1'b0, 32'h20, 3'd2, 32'h0, "ld_w20_old", old20);
      do_req(1'b0, 1'b1, 32'h21, 3'd0, 32'h0000_0080, "st_b21", rd);
      do_req(1'b0, 1'b0, 32'h21, 3'd0, 32'h0, "ld_b21", rd);
      check("ld_b21_const", rd, 32'hFFFF_FF80);
      do_req(1'b0, 1'b0, 32'h21, 3'd3, 32'h0, "ld_ub21", rd);
      check("ld_ub21_const", rd, 32'h0000_0080);
      do_req(1'b0, 1'b0, 32'h20, 3'd2, 32'h0, "ld_w20", rd);
      check("ld_w20_merge", rd, (old20 & 32'hFFFF_00FF) | 32'h0000_8000);

      // Split store and load across a word boundary
      do_req(1'b0, 1'b1, 32'h33, 3'd2, 32'h1122_3344, "st_w33", rd);
      do_req(1'b0, 1'b0, 32'h33, 3'd2, 32'h0, "ld_w33", rd);
      check("ld_w33_const", rd, 32'h1122_3344);
      do_req(1'b0, 1'b0, 32'h33, 3'd3, 32'h0, "ld_b33", rd);
      check("ld_b33_const", rd, 32'h44);
      do_req(1'b0, 1'b0, 32'h34, 3'd3, 32'h0, "ld_b34", rd);
      check("ld_b34_const", rd, 32'h33);
      do_req(1'b0, 1'b0, 32'h35, 3'd3, 32'h0, "ld_b35", rd);
      check("ld_b35_const", rd, 32'h22);
      do_req(1'b0, 1'b0, 32'h36, 3'd3, 32'h0, "ld_b36", rd);
      check("ld_b36_const", rd, 32'h11);

      // Faults
      do_req(1'b0, 1'b0, DEPTH - 2, 3'd2, 32'h0, "flt_range", rd);
      check("flt_range_rdata", rd, 32'h0);
      do_req(1'b0, 1'b0, 32'h0, 3'd7, 32'h0, "flt_mode7", rd);
      do_req(1'b0, 1'b1, 32'h8, 3'd5, 32'hFFFF_FFFF, "flt_mode5_st", rd);
      do_req(1'b0, 1'b0, 32'h8, 3'd2, 32'h0, "flt_mode5_chk", rd);
      do_req(1'b0, 1'b0, 32'hFFFF_FFFF, 3'd1, 32'h0, "flt_wrap", rd);
      do_req(1'b0, 1'b0, DEPTH - 1, 3'd3, 32'h0, "last_byte", rd);

      // Non-splitting instance: crossing access faults and leaves memory alone
      do_req(1'b1, 1'b1, 32'h40, 3'd2, 32'hA5A5_A5A5, "ns_st40", rd);
      do_req(1'b1, 1'b1, 32'h44, 3'd2, 32'h5A5A_5A5A, "ns_st44", rd);
      do_req(1'b1, 1'b1, 32'h43, 3'd1, 32'h0000_BEEF, "ns_st_h43", rd);
      do_req(1'b1, 1'b0, 32'h40, 3'd2, 32'h0, "ns_ld40", rd);
      check("ns_ld40_const", rd, 32'hA5A5_A5A5);
      do_req(1'b1, 1'b0, 32'h44, 3'd2, 32'h0, "ns_ld44", rd);
      check("ns_ld44_const", rd, 32'h5A5A_5A5A);
      do_req(1'b1, 1'b0, 32'h42, 3'd4, 32'h0, "ns_ld_uh42", rd);
      check("ns_ld_uh42_const", rd, 32'h0000_A5A5);

      // Eight back-to-back aligned requests with req_valid held high
      for (int i = 0; i < 8; i++) begin
         b2b_we[i]   = (i < 4);
         b2b_addr[i] = 32'h80 + 32'(4 * (i % 4));
         b2b_data[i] = $urandom;
      end
      @(negedge clk);
      a_valid = 1'b1; a_we = b2b_we[0]; a_addr = b2b_addr[0];
      a_mode = 3'd2; a_wdata = b2b_data[0];
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         model(1'b0, b2b_we[i], b2b_addr[i], 3'd2, b2b_data[i], erd, ef, es);
         #1;
         check($sformatf("b2b%0d_valid", i), 32'(a_rvalid), 32'd1);
         check($sformatf("b2b%0d_ready", i), 32'(a_ready), 32'd1);
         check($sformatf("b2b%0d_rdata", i), a_rdata, erd);
         if (i < 7) begin
            a_we = b2b_we[i+1]; a_addr = b2b_addr[i+1]; a_wdata = b2b_data[i+1];
         end else begin
            a_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      check("b2b_end", 32'(a_rvalid), 32'd0);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         logic [31:0] addr;
         logic [2:0]  mode;
         int unsigned r;
         r    = $urandom % 16;
         mode = (($urandom % 8) < 7) ? 3'($urandom % 5) : 3'(5 + $urandom % 3);
         if (r == 0)      addr = 32'(DEPTH - 1 - ($urandom % 4));
         else if (r == 1) addr = $urandom;
         else             addr = $urandom % DEPTH;
         do_req(1'b0, 1'($urandom % 2), addr, mode, $urandom, $sformatf("rnd%0d", n), rd);
      end

      // Reset asserted in the SPLIT cycle of a split store at 0x3E
      old40 = m_a[32'h40];
      old41 = m_a[32'h41];
      @(negedge clk);
      a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h3E; a_mode = 3'd2; a_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      check("rs_split_ready", 32'(a_ready), 32'd0);
      #1;
      rst_n = 1'b0;
      m_a[32'h3E] = 8'h0D;
      m_a[32'h3F] = 8'hF0;
      #1;
      check("rs_in_reset_valid", 32'(a_rvalid), 32'd0);
      check("rs_in_reset_ready", 32'(a_ready), 32'd0);
      @(posedge clk);
      #1;
      check("rs_no_rsp", 32'(a_rvalid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rs_ready_after", 32'(a_ready), 32'd1);
      @(posedge clk);
      #1;
      check("rs_no_late_rsp", 32'(a_rvalid), 32'd0);
      do_req(1'b0, 1'b0, 32'h3E, 3'd3, 32'h0, "rs_b3e", rd);
      check("rs_b3e_const", rd, 32'h0D);
      do_req(1'b0, 1'b0, 32'h3F, 3'd3, 32'h0, "rs_b3f", rd);
      check("rs_b3f_const", rd, 32'hF0);
      do_req(1'b0, 1'b0, 32'h40, 3'd3, 32'h0, "rs_b40", rd);
      check("rs_b40_old", rd, 32'(old40));
      do_req(1'b0, 1'b0, 32'h41, 3'd3, 32'h0, "rs_b41", rd);
      check("rs_b41_old", rd, 32'(old41));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule

// File: doc/lsu_dmem.md
# lsu_dmem

Parametrised, byte-addressable data memory for the load/store path of the pipelined RISC-V core. It replaces the single-cycle, unchecked byte-array memory with a request/response interface, synchronous reads, and byte-lane write enables. It adds range and mode fault detection, and hardware splitting of misaligned accesses that straddle a word boundary. It sits in the memory stage; the pipeline stalls on `req_ready` low and consumes `rsp_*` one or two cycles after issue.

## Interface
- `DEPTH_BYTES`, 1024: memory size in bytes; multiple of 4, power of two.
- `MISALIGN_SPLIT`, 1: 1 = misaligned word-crossing accesses are split into two beats; 0 = they fault.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on the edge where `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, LSB-aligned.
- `req_mode`  in  3  000 BYTE, 001 HALF, 010 WORD, 011 UBYTE, 100 UHALF; 101–111 illegal.
- `rsp_valid`  out  1  one-cycle response pulse; no back-pressure.
- `rsp_rdata`  out  32  extended load data; 0 for stores and faults.
- `rsp_fault`  out  1  access faulted; valid with `rsp_valid`.

## Operation
- Storage is `DEPTH_BYTES/4` words × 4 byte lanes, little-endian. Word index is `addr[..:2]`; offset is `addr[1:0]`.
- Access size: 1 for BYTE/UBYTE, 2 for HALF/UHALF, 4 for WORD. UBYTE/UHALF are load-only; as stores they behave as BYTE/HALF.
- Fault conditions (no memory write):
  - illegal mode;
  - `addr + size - 1 >= DEPTH_BYTES`, computed in 33 bits with no wrap-around;
  - `offset + size > 4` when `MISALIGN_SPLIT=0`.
- Lane mask is `((1<<size)-1) << offset`, 8 bits wide. Bits [3:0] apply to word `idx`; bits [7:4] apply to word `idx+1`.
- Store data is `req_wdata` rotated left by `offset*8`, 64 bits wide. The low half goes to `idx` and the high half to `idx+1`.
- Load data: form `{word(idx+1), word(idx)}`, shift right by `offset*8`, truncate to size, then extend:
  - sign-extend for BYTE/HALF/WORD;
  - zero-extend for UBYTE/UHALF.
- FSM states:
  - IDLE: `req_ready=1`.
    - Accepting an aligned or faulting request stays in IDLE.
    - Accepting a split request (`offset+size>4`, legal) moves to SPLIT. Beat 0 (word `idx`, mask[3:0]) is accessed on the accept edge.
  - SPLIT: `req_ready=0`. Beat 1 (word `idx+1`, mask[7:4]) is accessed on the next edge, then the FSM returns to IDLE.
- Request fields are registered on accept so that SPLIT is independent of `req_*`.
- Same-address store then load issued back-to-back: the load returns the new data, because the write completes at the store's accept edge.

## Timing
- Aligned or fault: accept at edge N; `rsp_valid=1` during cycle N+1. Throughput is 1 request per cycle.
- Split: accept at edge N; `req_ready=0` during cycle N+1; `rsp_valid=1` during cycle N+2.
- `rsp_valid` is high for exactly one cycle per accepted request.
- `req_ready` is combinational from state. It is 0 while `rst_n=0`.
- Reset values:
  - state IDLE;
  - `rsp_valid=0`, `rsp_rdata=0`, `rsp_fault=0`.
  - Memory contents are not reset.
- Reset during SPLIT:
  - beat 1 is abandoned and no response is produced;
  - beat-0 store bytes already written remain.
- `req_valid` while `req_ready=0` is ignored; the requester must hold it.

## Structure
- Package `dmem_pkg`:
  - `mem_mode_e` enum with the encodings above;
  - `state_e` (IDLE, SPLIT);
  - function `mode_size(mem_mode_e)` returning 1/2/4;
  - function `mode_signed(mem_mode_e)`.
- Sub-module `dmem_bank`: a single-port word array with 4-bit byte-write-enable and registered read. One instance is shared by both beats; at most one word is accessed per cycle.
- `lsu_dmem` contains:
  - FSM, request register, and fault check;
  - lane-mask and rotate logic;
  - a beat-0 holding register for split loads;
  - extension and response registers.

## Test plan
- Store WORD 0xDEADBEEF at 0x10, then load WORD at 0x10 → `rsp_rdata=0xDEADBEEF`, `rsp_fault=0`, 1-cycle latency; load UHALF at 0x12 → `0x0000DEAD`.
- Store BYTE 0x80 at 0x21; load BYTE at 0x21 → `0xFFFFFF80`; UBYTE → `0x00000080`; WORD at 0x20 → bytes 0x20/0x22/0x23 are unchanged.
- With `MISALIGN_SPLIT=1`:
  - store WORD 0x11223344 at 0x33 → `req_ready` low for 1 cycle, response at N+2;
  - load WORD at 0x33 → `0x11223344`;
  - bytes 0x33..0x36 read back as 0x44, 0x33, 0x22, 0x11.
- Faults:
  - load WORD at `DEPTH_BYTES-2` → `rsp_fault=1`, `rdata=0`;
  - mode 111 → fault;
  - with `MISALIGN_SPLIT=0`, HALF at offset 3 → fault, and memory is unchanged.
- Issue 8 aligned requests back-to-back with `req_valid` held high → 8 consecutive `rsp_valid` pulses in order.
- Assert `rst_n` low in the SPLIT cycle of a split store at 0x3E → no response; `req_ready=1` after release; bytes 0x3E–0x3F hold the new data and 0x40–0x41 hold the old data.
